doc_uart_sender: RTL and testbench

//  Dumps the recognised-text document to a host over UART on request. Sits downstream of the document RAM:

---
 rtl/doc_pkg.sv | 29 ++
 rtl/uart_tx_8n1.sv | 56 +++++
 rtl/doc_uart_sender.sv | 154 +++++++++++++++
 tb/tb_doc_uart_sender.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doc_pkg.sv
// Shared document constants and the sender FSM state type.
// Row and column fields are fixed at 4 and 5 bits so the address map stays stable.
package doc_pkg;

    localparam int DOC_ROWS   = 15;
    localparam int DOC_COLS   = 20;
    localparam int DOC_ADDR_W = 10;
    localparam int ROW_W      = 4;
    localparam int COL_W      = 5;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND_CHAR,
        SEND_CR,
        SEND_LF,
        FINISH
    } sender_state_t;

    function automatic logic [DOC_ADDR_W-1:0] doc_addr(input logic [ROW_W-1:0] row,
                                                        input logic [COL_W-1:0] col);
        return {1'b0, row, col};
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first, each bit held exactly CLK_HZ/BAUD clocks.
// Handshake: a byte is taken on a clock edge where valid and ready are both high; ready drops on
// that edge and rises again on the cycle after the stop bit's last clock.
module uart_tx_8n1 #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'd9;

    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            ready    <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
        end else if (ready) begin
            if (valid) begin
                // shreg[0] is the bit currently on the line; shifting in 1s keeps the tail idle-high
                shreg    <= {1'b1, data, 1'b0};
                tx       <= 1'b0;
                ready    <= 1'b0;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
                ready <= 1'b1;
                tx    <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= {1'b1, shreg[9:1]};
                tx      <= shreg[1];
            end
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/doc_uart_sender.sv
// Walks the document RAM row by row, sends each character over UART and ends every row with CR/LF.
// Pulses done once the final LF has fully left the line.
module doc_uart_sender
    import doc_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int ROWS   = DOC_ROWS,
    parameter int COLS   = DOC_COLS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  read_enable,
    output logic [DOC_ADDR_W-1:0] read_addr,
    input  logic [7:0]            read_data,
    output logic                  done,
    output logic                  busy,
    output logic                  tx,
    output sender_state_t         state_dbg
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    sender_state_t    state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             sent;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_byte;

    assign state_dbg = state;

    // FETCH offers the RAM byte directly; CR/LF states offer their byte until it has been taken once
    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = read_data;
        unique case (state)
            FETCH: begin
                tx_valid = 1'b1;
                tx_byte  = (read_data == 8'h00) ? ASCII_SP : read_data;
            end
            SEND_CR: begin
                tx_valid = !sent;
                tx_byte  = ASCII_CR;
            end
            SEND_LF: begin
                tx_valid = !sent;
                tx_byte  = ASCII_LF;
            end
            default: begin
                tx_valid = 1'b0;
                tx_byte  = read_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            sent        <= 1'b0;
            read_enable <= 1'b0;
            read_addr   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        row         <= '0;
                        col         <= '0;
                        sent        <= 1'b0;
                        busy        <= 1'b1;
                        read_enable <= 1'b1;
                        read_addr   <= doc_addr('0, '0);
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (tx_ready) begin
                        state <= SEND_CHAR;
                    end
                end
                SEND_CHAR: begin
                    if (tx_ready) begin
                        if (col < COL_LAST) begin
                            col       <= col + COL_W'(1);
                            read_addr <= doc_addr(row, col + COL_W'(1));
                            state     <= FETCH;
                        end else begin
                            // read_addr holds the last column until the next row starts
                            col   <= '0;
                            state <= SEND_CR;
                        end
                    end
                end
                SEND_CR: begin
                    if (tx_ready) begin
                        if (!sent) begin
                            sent <= 1'b1;
                        end else begin
                            sent  <= 1'b0;
                            state <= SEND_LF;
                        end
                    end
                end
                SEND_LF: begin
                    if (tx_ready) begin
                        if (!sent) begin
                            sent <= 1'b1;
                        end else begin
                            sent <= 1'b0;
                            if (row < ROW_LAST) begin
                                row       <= row + ROW_W'(1);
                                read_addr <= doc_addr(row + ROW_W'(1), '0);
                                state     <= FETCH;
                            end else begin
                                done        <= 1'b1;
                                busy        <= 1'b0;
                                read_enable <= 1'b0;
                                read_addr   <= '0;
                                state       <= FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    uart_tx_8n1 #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .valid(tx_valid),
        .data (tx_byte),
        .ready(tx_ready),
        .tx   (tx)
    );

endmodule

// File: tb/tb_doc_uart_sender.sv
// Bench for doc_uart_sender on a 2x3 document with DIV=10: table-driven dumps checked by a UART
// decoder against an expected byte queue, plus restart-while-busy and reset-mid-dump sequences.
module tb_doc_uart_sender;
  import doc_pkg::*;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = 10;
  localparam int ROWS   = 2;
  localparam int COLS   = 3;
  localparam int FRAME  = 10 * DIV;

  typedef struct packed {
    logic [47:0] doc;   // byte i = row i/3, col i%3 at [8*i +: 8]
    logic [79:0] expb;  // decoded line bytes in order, byte k at [8*k +: 8]
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            read_enable;
  logic [9:0]      read_addr;
  logic [7:0]      read_data;
  logic            done;
  logic            busy;
  logic            tx;
  sender_state_t   state_dbg;

  logic [7:0] doc_mem [0:1023];
  assign read_data = doc_mem[read_addr];

  logic [7:0] exp_q[$];
  logic [9:0] addr_q[$];

  int total = 0;
  int bad = 0;

  // monitor state
  bit         mon_en = 1'b0;
  bit         mon_in_frame = 1'b0;
  int         mon_k = 0;
  int         mon_idle = 0;
  logic [9:0] mon_bits = '0;
  bit         mon_glitch = 1'b0;
  int         frame_cnt = 0;
  int         frames_in_dump = 0;
  int         done_cnt = 0;
  bit         addr_seen = 1'b0;
  logic [9:0] last_addr = '0;

  vec_t vecs [0:2];

  doc_uart_sender #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .ROWS  (ROWS),
    .COLS  (COLS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .read_enable(read_enable),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .done       (done),
    .busy       (busy),
    .tx         (tx),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // UART decoder, done counter and read_addr tracker, all sampled on the falling edge
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_in_frame = 1'b0;
    end else if (rst) begin
      mon_in_frame   = 1'b0;
      mon_idle       = 0;
      frames_in_dump = 0;
      addr_seen      = 1'b0;
    end else begin
      if (!mon_in_frame) begin
        if (tx == 1'b0) begin
          if (frames_in_dump > 0) check("gap", 32'(mon_idle <= 2), 32'd1);
          mon_in_frame = 1'b1;
          mon_k        = 1;
          mon_bits     = '0;
          mon_glitch   = 1'b0;
        end else begin
          mon_idle++;
        end
      end else begin
        if (mon_k % DIV == 0) mon_bits[mon_k / DIV] = tx;
        else if (tx !== mon_bits[mon_k / DIV]) mon_glitch = 1'b1;
        mon_k++;
        if (mon_k == FRAME) begin
          mon_in_frame = 1'b0;
          mon_idle     = 0;
          check("frame_shape", {30'd0, mon_glitch, mon_bits[9]}, 32'd1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL byte: actual=%0h required=none", mon_bits[8:1]);
          end else begin
            check("byte", 32'(mon_bits[8:1]), 32'(exp_q.pop_front()));
          end
          frame_cnt++;
          frames_in_dump++;
        end
      end

      if (done) begin
        done_cnt++;
        check("done_after_lf", {30'd0, mon_in_frame, exp_q.size() == 0}, 32'd1);
        frames_in_dump = 0;
      end

      if (read_enable) begin
        if (!addr_seen || read_addr != last_addr) begin
          if (addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL read_addr: actual=%0d required=none", read_addr);
          end else begin
            check("read_addr", 32'(read_addr), 32'(addr_q.pop_front()));
          end
          last_addr = read_addr;
          addr_seen = 1'b1;
        end
      end else begin
        addr_seen = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic load_and_expect(input logic [47:0] doc, input logic [79:0] expb);
    for (int i = 0; i < 6; i++) doc_mem[{1'b0, 4'(i / 3), 5'(i % 3)}] = doc[8*i +: 8];
    for (int k = 0; k < 10; k++) exp_q.push_back(expb[8*k +: 8]);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) addr_q.push_back(10'(r * 32 + c));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_dump(input logic [47:0] doc, input logic [79:0] expb, input int restart_at);
    int  base_frames;
    int  base_done;
    bit  restarted;
    bit  finished;
    load_and_expect(doc, expb);
    base_frames = frame_cnt;
    base_done   = done_cnt;
    restarted   = 1'b0;
    finished    = 1'b0;
    pulse_start();
    for (int c = 0; c < 4000 && !finished; c++) begin
      @(posedge clk); #1;
      if (restart_at >= 0 && !restarted && frame_cnt - base_frames == restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_cnt != base_done) finished = 1'b1;
    end
    start = 1'b0;
    check("dump_done", 32'(finished), 32'd1);
    repeat (40) @(negedge clk);
    check("done_pulses", 32'(done_cnt - base_done), 32'd1);
    check("frames", 32'(frame_cnt - base_frames), 32'd10);
    check("queues_empty", 32'(exp_q.size() + addr_q.size()), 32'd0);
    check("idle_outputs", {28'd0, busy, read_enable, tx, done}, 32'b0010);
    check("idle_addr", 32'(read_addr), 32'd0);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic rst_mid_dump();
    int  base_frames;
    int  base_done;
    bit  hit;
    load_and_expect(vecs[0].doc, vecs[0].expb);
    base_frames = frame_cnt;
    base_done   = done_cnt;
    hit         = 1'b0;
    pulse_start();
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(posedge clk); #1;
      if (frame_cnt - base_frames == 2 && mon_in_frame && mon_k == 4 * DIV + 5) hit = 1'b1;
    end
    check("reached_byte3", 32'(hit), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {28'd0, tx, busy, done, read_enable}, 32'b1000);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - base_done), 32'd0);
    check("rst_line_idle", {31'd0, tx}, 32'd1);
  endtask

  // main sequence
  initial begin
    logic [47:0] rdoc;
    logic [79:0] rexp;
    logic [7:0]  b;
    int          k;

    vecs[0] = '{doc:  {8'h7A, 8'h79, 8'h78, 8'h43, 8'h42, 8'h41},
                expb: {8'h0A, 8'h0D, 8'h7A, 8'h79, 8'h78, 8'h0A, 8'h0D, 8'h43, 8'h42, 8'h41}};
    vecs[1] = '{doc:  {8'h7E, 8'h00, 8'h00, 8'h00, 8'h41, 8'h00},
                expb: {8'h0A, 8'h0D, 8'h7E, 8'h20, 8'h20, 8'h0A, 8'h0D, 8'h20, 8'h41, 8'h20}};
    vecs[2] = '{doc:  {8'h80, 8'h01, 8'h0D, 8'h20, 8'hFF, 8'h30},
                expb: {8'h0A, 8'h0D, 8'h80, 8'h01, 8'h0D, 8'h0A, 8'h0D, 8'h20, 8'hFF, 8'h30}};
    for (int i = 0; i < 1024; i++) doc_mem[i] = 8'h00;

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {28'd0, tx, busy, done, read_enable}, 32'b1000);
    check("reset_addr", 32'(read_addr), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 3; v++) run_dump(vecs[v].doc, vecs[v].expb, -1);

    // start pulsed again while the fourth byte is on the line
    run_dump(vecs[0].doc, vecs[0].expb, 3);

    rst_mid_dump();
    run_dump(vecs[0].doc, vecs[0].expb, -1);

    for (int n = 0; n < 2; n++) begin
      k = 0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          rdoc[8*(r*COLS + c) +: 8] = b;
          rexp[8*k +: 8] = (b == 8'h00) ? 8'h20 : b;
          k++;
        end
        rexp[8*k +: 8] = 8'h0D; k++;
        rexp[8*k +: 8] = 8'h0A; k++;
      end
      run_dump(rdoc, rexp, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
